// File: rtl/step_gen_pkg.sv
// Shared types and helpers for the step/dir pulse generator.
package step_gen_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StHigh,
        StLow,
        StDone
    } state_e;

    localparam int unsigned DefPulseCycles = 4;
    localparam int unsigned DefDirSetup    = 2;

    // Rise-to-rise period never shorter than equal high and low times.
    function automatic int unsigned peff_clamp(input int unsigned period,
                                               input int unsigned pulse_cycles);
        return (period > 2 * pulse_cycles) ? period : 2 * pulse_cycles;
    endfunction

endpackage

// File: rtl/step_timer.sv
// Loadable down-counter; expire is high for the last cycle of a loaded interval.
module step_timer #(
    parameter int unsigned DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [DIV_W-1:0] value,
    output logic             expire
);

    logic [DIV_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= value;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - DIV_W'(1);
        end
    end

    // A load of V makes the owner act on the V-th following clock edge.
    assign expire = (cnt_q == DIV_W'(1));

endmodule

// File: rtl/step_dir_pulse_gen.sv
// Command-side step/dir generator: accepts a move and emits timed step pulses.
module step_dir_pulse_gen
    import step_gen_pkg::*;
#(
    parameter int unsigned CNT_W        = 16,
    parameter int unsigned DIV_W        = 16,
    parameter int unsigned PULSE_CYCLES = DefPulseCycles,
    parameter int unsigned DIR_SETUP    = DefDirSetup
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [CNT_W-1:0] cmd_steps,
    input  logic             cmd_dir,
    input  logic [DIV_W-1:0] cmd_period,
    input  logic             cmd_half_step,
    input  logic             abort,
    input  logic             en_hold,
    output logic             step,
    output logic             dir,
    output logic             en,
    output logic             half_step,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [CNT_W-1:0] steps_done
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] steps_q, steps_d;
    logic [DIV_W-1:0] peff_q, peff_d;
    logic [CNT_W-1:0] steps_done_q, steps_done_d;
    logic             step_q, step_d;
    logic             dir_q, dir_d;
    logic             half_q, half_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             aborted_q, aborted_d;
    logic             abort_pend_q, abort_pend_d;

    logic             timer_load;
    logic [DIV_W-1:0] timer_value;
    logic             timer_expire;
    logic             abort_now;

    step_timer #(
        .DIV_W(DIV_W)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (timer_load),
        .value (timer_value),
        .expire(timer_expire)
    );

    assign cmd_ready = (state_q == StIdle) & ~abort;
    assign abort_now = abort_pend_q | abort;

    always_comb begin
        state_d      = state_q;
        steps_d      = steps_q;
        peff_d       = peff_q;
        steps_done_d = steps_done_q;
        step_d       = step_q;
        dir_d        = dir_q;
        half_d       = half_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        aborted_d    = aborted_q;
        abort_pend_d = abort_pend_q;
        timer_load   = 1'b0;
        timer_value  = '0;

        unique case (state_q)
            StIdle: begin
                if (cmd_valid && cmd_ready) begin
                    steps_d      = cmd_steps;
                    peff_d       = DIV_W'(peff_clamp(32'(cmd_period), PULSE_CYCLES));
                    dir_d        = cmd_dir;
                    half_d       = cmd_half_step;
                    steps_done_d = '0;
                    aborted_d    = 1'b0;
                    abort_pend_d = 1'b0;
                    if (cmd_steps == '0) begin
                        done_d  = 1'b1;
                        state_d = StDone;
                    end else begin
                        busy_d      = 1'b1;
                        timer_load  = 1'b1;
                        timer_value = DIV_W'(DIR_SETUP);
                        state_d     = StSetup;
                    end
                end
            end
            StSetup, StLow: begin
                if (abort) abort_pend_d = 1'b1;
                if (timer_expire) begin
                    if (abort_now || (state_q == StLow && steps_done_q == steps_q)) begin
                        done_d    = 1'b1;
                        aborted_d = abort_now;
                        state_d   = StDone;
                    end else begin
                        step_d       = 1'b1;
                        steps_done_d = steps_done_q + CNT_W'(1);
                        timer_load   = 1'b1;
                        timer_value  = DIV_W'(PULSE_CYCLES);
                        state_d      = StHigh;
                    end
                end
            end
            StHigh: begin
                // The pulse always runs its full width; abort only takes effect after LOW.
                if (abort) abort_pend_d = 1'b1;
                if (timer_expire) begin
                    step_d      = 1'b0;
                    timer_load  = 1'b1;
                    timer_value = peff_q - DIV_W'(PULSE_CYCLES);
                    state_d     = StLow;
                end
            end
            StDone: begin
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            steps_q      <= '0;
            peff_q       <= '0;
            steps_done_q <= '0;
            step_q       <= 1'b0;
            dir_q        <= 1'b0;
            half_q       <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            aborted_q    <= 1'b0;
            abort_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            steps_q      <= steps_d;
            peff_q       <= peff_d;
            steps_done_q <= steps_done_d;
            step_q       <= step_d;
            dir_q        <= dir_d;
            half_q       <= half_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            aborted_q    <= aborted_d;
            abort_pend_q <= abort_pend_d;
        end
    end

    assign step       = step_q;
    assign dir        = dir_q;
    assign half_step  = half_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign aborted    = aborted_q;
    assign steps_done = steps_done_q;
    assign en         = busy_q | en_hold;

endmodule

// File: tb/tb_step_dir_pulse_gen.sv
// Directed self-checking bench for step_dir_pulse_gen (PULSE_CYCLES=4, DIR_SETUP=2).
module tb_step_dir_pulse_gen;

    localparam int CNT_W = 16;
    localparam int DIV_W = 16;
    localparam int PULSE = 4;
    localparam int SETUP = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [CNT_W-1:0] cmd_steps = '0;
    logic             cmd_dir = 1'b0;
    logic [DIV_W-1:0] cmd_period = '0;
    logic             cmd_half_step = 1'b0;
    logic             abort = 1'b0;
    logic             en_hold = 1'b0;
    logic             step, dir, en, half_step, busy, done, aborted;
    logic [CNT_W-1:0] steps_done;

    int checks = 0;
    int errors = 0;

    step_dir_pulse_gen #(
        .CNT_W       (CNT_W),
        .DIV_W       (DIV_W),
        .PULSE_CYCLES(PULSE),
        .DIR_SETUP   (SETUP)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_steps    (cmd_steps),
        .cmd_dir      (cmd_dir),
        .cmd_period   (cmd_period),
        .cmd_half_step(cmd_half_step),
        .abort        (abort),
        .en_hold      (en_hold),
        .step         (step),
        .dir          (dir),
        .en           (en),
        .half_step    (half_step),
        .busy         (busy),
        .done         (done),
        .aborted      (aborted),
        .steps_done   (steps_done)
    );

    always #5 clk = ~clk;

    // k counts clock edges after the accept edge; values are sampled at the following negedge.
    function automatic logic exp_step(input int k, input int n, input int p);
        for (int j = 0; j < n; j++) begin
            if (k >= SETUP + j * p && k < SETUP + j * p + PULSE) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic int exp_count(input int k, input int n, input int p);
        int c = 0;
        for (int j = 0; j < n; j++) begin
            if (k >= SETUP + j * p) c++;
        end
        return c;
    endfunction

    // Presents a command for one edge; returns at the negedge just after the accept edge.
    task automatic accept(input int steps_in, input logic d, input int period, input logic hs);
        @(negedge clk);
        cmd_valid     = 1'b1;
        cmd_steps     = CNT_W'(steps_in);
        cmd_dir       = d;
        cmd_period    = DIV_W'(period);
        cmd_half_step = hs;
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL accept_ready: got %b want 1", cmd_ready);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        en_hold = 1'b1;
        #1;
        checks++;
        if ({step, dir, half_step, busy, done, aborted, en} !== 7'b0000001 || steps_done !== '0) begin
            errors++;
            $display("FAIL reset_state: got %b/%0d want 0000001/0",
                     {step, dir, half_step, busy, done, aborted, en}, steps_done);
        end
        en_hold = 1'b0;
        #1;
        checks++;
        if (en !== 1'b0) begin
            errors++;
            $display("FAIL reset_en: got %b want 0", en);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL idle_ready: got %b want 1", cmd_ready);
        end
        abort = 1'b1;
        #1;
        checks++;
        if (cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL abort_blocks_ready: got %b want 0", cmd_ready);
        end
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if ({busy, done, aborted} !== 3'b000) begin
            errors++;
            $display("FAIL idle_abort_ignored: got %b want 000", {busy, done, aborted});
        end
    endtask

    task automatic test_basic();
        logic [5:0] exp_v;
        accept(3, 1'b1, 10, 1'b1);
        for (int k = 0; k <= 34; k++) begin
            exp_v = {exp_step(k, 3, 10), k == 32, k <= 32, k <= 32, 1'b1, 1'b1};
            checks++;
            if ({step, done, busy, en, dir, half_step} !== exp_v) begin
                errors++;
                $display("FAIL basic k=%0d step/done/busy/en/dir/hs: got %b want %b",
                         k, {step, done, busy, en, dir, half_step}, exp_v);
            end
            checks++;
            if (steps_done !== CNT_W'(exp_count(k, 3, 10))) begin
                errors++;
                $display("FAIL basic_count k=%0d: got %0d want %0d", k, steps_done,
                         exp_count(k, 3, 10));
            end
            @(negedge clk);
        end
    endtask

    task automatic test_zero();
        accept(0, 1'b0, 10, 1'b0);
        for (int k = 0; k <= 3; k++) begin
            checks++;
            if ({step, done, busy, cmd_ready} !== {1'b0, k == 0, 1'b0, k != 0}
                || steps_done !== '0) begin
                errors++;
                $display("FAIL zero k=%0d step/done/busy/ready: got %b/%0d want %b/0", k,
                         {step, done, busy, cmd_ready}, steps_done,
                         {1'b0, k == 0, 1'b0, k != 0});
            end
            @(negedge clk);
        end
    endtask

    task automatic test_clamp();
        // period 3 is clamped to 2*PULSE = 8.
        accept(2, 1'b1, 3, 1'b0);
        for (int k = 0; k <= 20; k++) begin
            checks++;
            if ({step, done, busy} !== {exp_step(k, 2, 8), k == 18, k <= 18}) begin
                errors++;
                $display("FAIL clamp k=%0d step/done/busy: got %b want %b", k,
                         {step, done, busy}, {exp_step(k, 2, 8), k == 18, k <= 18});
            end
            @(negedge clk);
        end
    endtask

    task automatic test_abort();
        accept(10, 1'b0, 10, 1'b0);
        for (int k = 0; k <= 15; k++) begin
            checks++;
            if ({step, done, busy, aborted} !== {k >= 2 && k < 6, k == 12, k <= 12, k >= 12}
                || steps_done !== CNT_W'(k >= 2 ? 1 : 0)) begin
                errors++;
                $display("FAIL abort k=%0d step/done/busy/aborted: got %b/%0d want %b/%0d", k,
                         {step, done, busy, aborted}, steps_done,
                         {k >= 2 && k < 6, k == 12, k <= 12, k >= 12}, k >= 2 ? 1 : 0);
            end
            if (k == 3) abort = 1'b1;
            if (k == 4) abort = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        cmd_valid     = 1'b1;
        cmd_steps     = CNT_W'(1);
        cmd_dir       = 1'b1;
        cmd_period    = DIV_W'(10);
        cmd_half_step = 1'b0;
        @(negedge clk);
        // Source now holds the next command while the first one runs.
        cmd_dir       = 1'b0;
        cmd_half_step = 1'b1;
        for (int k = 0; k <= 13; k++) begin
            checks++;
            if ({cmd_ready, step, done, dir, half_step} !==
                {k == 13, exp_step(k, 1, 10), k == 12, 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL b2b_first k=%0d ready/step/done/dir/hs: got %b want %b", k,
                         {cmd_ready, step, done, dir, half_step},
                         {k == 13, exp_step(k, 1, 10), k == 12, 1'b1, 1'b0});
            end
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        for (int k = 0; k <= 13; k++) begin
            checks++;
            if ({step, done, busy, dir, half_step} !==
                {exp_step(k, 1, 10), k == 12, k <= 12, 1'b0, 1'b1}) begin
                errors++;
                $display("FAIL b2b_second k=%0d step/done/busy/dir/hs: got %b want %b", k,
                         {step, done, busy, dir, half_step},
                         {exp_step(k, 1, 10), k == 12, k <= 12, 1'b0, 1'b1});
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid();
        en_hold = 1'b1;
        accept(3, 1'b1, 10, 1'b0);
        repeat (4) @(negedge clk);
        checks++;
        if (step !== 1'b1) begin
            errors++;
            $display("FAIL midreset_pre: step got %b want 1", step);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({step, busy, dir, done, en} !== 5'b00001 || steps_done !== '0) begin
            errors++;
            $display("FAIL midreset_async: step/busy/dir/done/en got %b/%0d want 00001/0",
                     {step, busy, dir, done, en}, steps_done);
        end
        en_hold = 1'b0;
        #1;
        checks++;
        if (en !== 1'b0) begin
            errors++;
            $display("FAIL midreset_en: got %b want 0", en);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero();
        test_clamp();
        test_abort();
        test_back_to_back();
        test_reset_mid();
        test_basic();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/step_dir_pulse_gen.md
Name: step_dir_pulse_gen

Overview:
- Command-side initiator for the step/dir/enable/half-step coil driver.
- Accepts a motion command (step count, direction, period, half-step mode) over a valid/ready handshake.
- Emits clean, timing-controlled step pulses with a direction set up ahead of the first pulse, and the en and half_step levels the coil driver consumes.
- Sits between the motion controller (CPU/UART command decoder) and the coil driver.

Parameters:
CNT_W, 16, width of step count and steps_done
DIV_W, 16, width of the step period in clk cycles
PULSE_CYCLES, 4, step high time in clk cycles (>=1)
DIR_SETUP, 2, clk cycles from command accept to the first step rising edge (>=1)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  block can accept a command
cmd_steps  in  CNT_W  number of step pulses to emit
cmd_dir  in  1  direction level for the move
cmd_period  in  DIV_W  clk cycles per step (rise-to-rise)
cmd_half_step  in  1  half-step mode for the move
abort  in  1  stop the move at the next safe point
en_hold  in  1  keep en asserted while idle (holding torque)
step  out  1  step pulse to the driver
dir  out  1  direction to the driver
en  out  1  driver enable
half_step  out  1  half-step select to the driver
busy  out  1  move in progress
done  out  1  one-cycle pulse at move end
aborted  out  1  last move ended by abort (sticky until next accept)
steps_done  out  CNT_W  pulses emitted in the current/last move

Behaviour:
- Reset (asynchronous, takes effect immediately, even mid-pulse):
  - step=0, dir=0, half_step=0, busy=0, done=0, aborted=0, steps_done=0, state=IDLE.
  - en=en_hold (combinational: en = busy | en_hold).
- All outputs are registered except en and cmd_ready.
- cmd_ready = (state==IDLE) & ~abort.
- Accept occurs on a clk edge where cmd_valid & cmd_ready.
- Effective period Peff = max(cmd_period, 2*PULSE_CYCLES), computed at accept and latched.
- States:
  - IDLE: on accept, latch steps/Peff; dir<=cmd_dir; half_step<=cmd_half_step; steps_done<=0; aborted<=0.
    - If cmd_steps==0: go to DONE.
    - Otherwise: busy<=1, load timer with DIR_SETUP, go to SETUP.
  - SETUP: dir/half_step are stable. On timer expiry go to HIGH: step<=1, steps_done+=1, load timer with PULSE_CYCLES.
  - HIGH: on timer expiry, step<=0, load timer with Peff-PULSE_CYCLES, go to LOW.
  - LOW: on timer expiry:
    - If remaining==0 or abort_pending: go to DONE.
    - Otherwise: enter HIGH (same actions as the SETUP exit).
  - DONE: held for 1 cycle with done=1. busy<=0 on exit; return to IDLE.
- Timing: step rising edges occur at accept+DIR_SETUP+k*Peff. done is high for the cycle starting at accept+DIR_SETUP+N*Peff. busy is high from accept until that point.
- Abort handling:
  - abort in SETUP, or in LOW, sets abort_pending and acts at the next timer expiry.
  - abort in HIGH is latched; the pulse is never truncated, and LOW runs to completion so the driver's minimum low time is met.
  - Final state on abort: aborted=1, done pulses once.
  - abort in IDLE or DONE is ignored, except that it blocks cmd_ready.
- dir and half_step never change while busy; they hold their values after done until the next accept.
- steps_done never wraps; it is bounded by cmd_steps (at most 2^CNT_W-1).
- cmd_valid while busy is not accepted; cmd_ready=0 and the command must be held by the source.

Decomposition:
- Package step_gen_pkg: state enum (IDLE, SETUP, HIGH, LOW, DONE); default PULSE_CYCLES/DIR_SETUP constants; Peff min helper function.
- One sub-module, step_timer: DIV_W down-counter with load/value inputs and a one-cycle expire output. The FSM and counters stay in the top level.

Test Plan:
- Basic move, PULSE_CYCLES=4, DIR_SETUP=2; accept steps=3, period=10, dir=1 at T0 -> step rises T0+2/12/22 (4 high each); dir=1 from T0+1; done at T0+32; steps_done=3; busy=0 after.
- Zero steps: accept steps=0 -> no step pulse; done the cycle after accept; busy stays 0; steps_done=0.
- Period clamp: period=3 -> rise-to-rise spacing 8 cycles; high 4 / low 4.
- Abort mid-pulse: steps=10, period=10, abort one cycle at T0+4 -> pulse completes (falls T0+6); no further pulses; done at T0+12; aborted=1; steps_done=1.
- Back-to-back and handshake: hold cmd_valid through a move -> cmd_ready=0 while busy; second command accepted in the first IDLE cycle after done; new dir latched without glitching step.
- Async reset at T0+4 (step high) -> step/busy/dir=0 immediately; en follows en_hold; next accept works normally.
